subtractor: RTL and testbench

- Registered, parameterised unsigned subtractor computing in1 - in2 over a ripple-borrow chain of per-bit full-subtractor cells.
- Sits in the datapath as a single-cycle arithmetic stage.
- Supplies a borrow (underflow) flag and a zero flag.
- Intended use is in1 >= in2; underflow is still fully defined (wrap or clamp, per parameter).

---
 rtl/subtractor.sv | 66 ++++++
 tb/tb_subtractor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/subtractor.sv
// Registered unsigned subtractor: in1 - in2 through a ripple-borrow chain of
// full-subtractor cells, with registered borrow (underflow) and zero flags.
module subtractor #(
  parameter int unsigned bits     = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [bits-1:0] in1,
  input  logic [bits-1:0] in2,
  output logic [bits-1:0] out,
  output logic            out_valid,
  output logic            borrow,
  output logic            zero
);

  logic [bits-1:0] diff;
  logic            borrow_d;
  logic [bits-1:0] out_d;
  logic            zero_d;

  logic [bits-1:0] out_q;
  logic            out_valid_q;
  logic            borrow_q;
  logic            zero_q;

  // Borrow is carried in a scalar so the chain has no self-referencing vector.
  always_comb begin
    logic br;
    diff = '0;
    br   = 1'b0;
    for (int unsigned i = 0; i < bits; i++) begin
      diff[i] = in1[i] ^ in2[i] ^ br;
      br      = (~in1[i] & in2[i]) | (~(in1[i] ^ in2[i]) & br);
    end
    borrow_d = br;
  end

  always_comb begin
    out_d  = (SATURATE && borrow_d) ? '0 : diff;
    zero_d = (out_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_q    <= out_d;
        borrow_q <= borrow_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_subtractor.sv
// Directed checks of subtractor in 8-bit wrap, 8-bit saturate and 16-bit wrap
// configurations, plus a short random sweep against a behavioural model.
module tb_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;

  logic [7:0]  w_out, s_out;
  logic        w_ov, w_br, w_z, s_ov, s_br, s_z;
  logic [15:0] x_out;
  logic        x_ov, x_br, x_z;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  subtractor #(.bits(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(vld), .in1(a8), .in2(b8),
    .out(w_out), .out_valid(w_ov), .borrow(w_br), .zero(w_z)
  );

  subtractor #(.bits(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(vld), .in1(a8), .in2(b8),
    .out(s_out), .out_valid(s_ov), .borrow(s_br), .zero(s_z)
  );

  subtractor #(.bits(16), .SATURATE(1'b0)) u_wide (
    .clk(clk), .rst(rst), .in_valid(vld), .in1(a16), .in2(b16),
    .out(x_out), .out_valid(x_ov), .borrow(x_br), .zero(x_z)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic step(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] aw, input logic [15:0] bw);
    @(negedge clk);
    rst = r; vld = v; a8 = a; b8 = b; a16 = aw; b16 = bw;
    @(posedge clk);
    #1;
  endtask

  task automatic check_wrap(input string tag, input logic [7:0] o, input logic ov,
                            input logic br, input logic z);
    check({tag, ".out"}, 16'(w_out), 16'(o));
    check({tag, ".ov"},  16'(w_ov),  16'(ov));
    check({tag, ".br"},  16'(w_br),  16'(br));
    check({tag, ".z"},   16'(w_z),   16'(z));
  endtask

  task automatic check_sat(input string tag, input logic [7:0] o, input logic ov,
                           input logic br, input logic z);
    check({tag, ".sout"}, 16'(s_out), 16'(o));
    check({tag, ".sov"},  16'(s_ov),  16'(ov));
    check({tag, ".sbr"},  16'(s_br),  16'(br));
    check({tag, ".sz"},   16'(s_z),   16'(z));
  endtask

  typedef struct {
    logic [7:0] a, b, o;
    logic       z;
  } vec_t;

  vec_t nominal [5] = '{
    '{8'd0,   8'd0,   8'd0,   1'b1},
    '{8'd125, 8'd0,   8'd125, 1'b0},
    '{8'd125, 8'd100, 8'd25,  1'b0},
    '{8'd255, 8'd1,   8'd254, 1'b0},
    '{8'd200, 8'd200, 8'd0,   1'b1}
  };

  initial begin
    rst = 1'b1; vld = 1'b0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;

    // Reset with in_valid asserted: reset must win on both cycles.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 8'd125, 8'd0, 16'd125, 16'd0);
      check_wrap("reset", 8'd0, 1'b0, 1'b0, 1'b0);
      check_sat("reset", 8'd0, 1'b0, 1'b0, 1'b0);
      check("reset.wide", x_out, 16'd0);
    end

    foreach (nominal[i]) begin
      step(1'b0, 1'b1, nominal[i].a, nominal[i].b, 16'd0, 16'd0);
      check_wrap($sformatf("nom%0d", i), nominal[i].o, 1'b1, 1'b0, nominal[i].z);
      check_sat($sformatf("nom%0d", i), nominal[i].o, 1'b1, 1'b0, nominal[i].z);
    end

    // Underflow: wrap vs clamp; 16-bit width vectors ride along.
    step(1'b0, 1'b1, 8'd5, 8'd10, 16'd65535, 16'd1);
    check_wrap("uf5_10", 8'd251, 1'b1, 1'b1, 1'b0);
    check_sat("uf5_10", 8'd0, 1'b1, 1'b1, 1'b1);
    check("w16.out", x_out, 16'd65534);
    check("w16.br", 16'(x_br), 16'd0);

    step(1'b0, 1'b1, 8'd0, 8'd1, 16'd0, 16'd1);
    check_wrap("uf0_1", 8'd255, 1'b1, 1'b1, 1'b0);
    check_sat("uf0_1", 8'd0, 1'b1, 1'b1, 1'b1);
    check("w16uf.out", x_out, 16'd65535);
    check("w16uf.br", 16'(x_br), 16'd1);
    check("w16uf.z", 16'(x_z), 16'd0);

    step(1'b0, 1'b1, 8'd10, 8'd5, 16'd0, 16'd0);
    check_wrap("ok10_5", 8'd5, 1'b1, 1'b0, 1'b0);
    check_sat("ok10_5", 8'd5, 1'b1, 1'b0, 1'b0);
    check("w16z.z", 16'(x_z), 16'd1);

    step(1'b0, 1'b1, 8'd255, 8'd0, 16'd0, 16'd0);
    check_wrap("max_0", 8'd255, 1'b1, 1'b0, 1'b0);

    // Hold: operands change while in_valid is low.
    step(1'b0, 1'b1, 8'd125, 8'd100, 16'd0, 16'd0);
    check_wrap("r25", 8'd25, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd3, 8'd200, 16'd7, 16'd9);
    check_wrap("hold1", 8'd25, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 16'd1, 16'd2);
    check_wrap("hold2", 8'd25, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 8'd200, 8'd50, 16'd0, 16'd0);
    check_wrap("midrst", 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'd200, 8'd50, 16'd0, 16'd0);
    check_wrap("after", 8'd150, 1'b1, 1'b0, 1'b0);

    // Random sweep against a behavioural model.
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  ra, rb, ew;
      logic [15:0] wa, wb, ex;
      ra = 8'($urandom); rb = 8'($urandom);
      wa = 16'($urandom); wb = 16'($urandom);
      if (i % 7 == 0) rb = ra;
      ew = ra - rb;
      ex = wa - wb;
      step(1'b0, 1'b1, ra, rb, wa, wb);
      check_wrap($sformatf("rnd%0d", i), ew, 1'b1, ra < rb, ew == 8'd0);
      check_sat($sformatf("rnd%0d", i), (ra < rb) ? 8'd0 : ew, 1'b1, ra < rb,
                (ra <= rb));
      check($sformatf("rnd%0d.x", i), x_out, ex);
      check($sformatf("rnd%0d.xb", i), 16'(x_br), 16'(wa < wb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
